// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encodings and the
// hold-counter width rule, used by the RTL and its bench alike.
package truth_table_sweeper_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // A one-cycle hold still needs a 1-bit counter so the declaration stays legal.
  function automatic int hold_cnt_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between a sweep controller (master) and the sweeper (slave).
interface truth_table_sweeper_if #(
  parameter int N = 4
);
  logic         start;
  logic         dut_out;
  logic [N-1:0] stim;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail;
  logic         fail_valid;

  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, err_count, first_fail, fail_valid
  );

  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, err_count, first_fail, fail_valid
  );
endinterface

// File: rtl/truth_table_sweeper_hold_timer.sv
// Counts 0..HOLD-1 while enabled and flags the final cycle of each hold window.
module hold_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int           W   = hold_cnt_w(HOLD);
  localparam logic [W-1:0] TOP = W'(HOLD - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign last = (cnt == TOP);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= last ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every N-bit input vector for HOLD cycles, compares the response
// against EXPECT and reports error count and the first failing vector.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int              N      = 4,
  parameter int              HOLD   = 10,
  parameter logic [2**N-1:0] EXPECT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_sweeper_if.slave   bus
);

  localparam logic [N-1:0] LAST_VEC = '1;
  localparam logic [N-1:0] STIM_ONE = N'(1);
  localparam logic [N:0]   ERR_ONE  = (N+1)'(1);

  logic [1:0]   state;
  logic [N-1:0] stim;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail;
  logic         fail_valid;
  logic         run;
  logic         accept;
  logic         hold_last;
  logic         mismatch;

  assign run      = (state == ST_RUN);
  // A start seen in RUN is ignored; from IDLE or FINISH it (re)launches a sweep.
  assign accept   = ((state == ST_IDLE) || (state == ST_FINISH)) && bus.start;
  assign mismatch = (bus.dut_out != EXPECT[stim]);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (run),
    .last   (hold_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      stim       <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (bus.start) begin
            state      <= ST_RUN;
            stim       <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          if (hold_last) begin
            if (mismatch) begin
              err_count <= err_count + ERR_ONE;
              if (!fail_valid) begin
                first_fail <= stim;
                fail_valid <= 1'b1;
              end
            end
            // End of sweep is the all-ones vector, so stim never wraps to 0.
            if (stim == LAST_VEC) begin
              state <= ST_FINISH;
            end else begin
              stim <= stim + STIM_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stim       = stim;
  assign bus.busy       = run;
  assign bus.done       = (state == ST_FINISH);
  assign bus.pass       = (state == ST_FINISH) && (err_count == '0);
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;
  assign bus.fail_valid = fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (HOLD=10 and HOLD=1) driving random truth tables.
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  localparam int          N      = 4;
  localparam int          HOLD_A = 10;
  localparam int          HOLD_B = 1;
  localparam logic [15:0] EXP_A  = 16'h8000;
  localparam logic [15:0] EXP_B  = 16'hFFFF;

  typedef struct {
    int errs;
    int ff;
    int fv;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tbl_a;
  logic [15:0] tbl_b;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic        done_a_q = 1'b0;
  logic        done_b_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sweeper_if #(.N(N)) bus_a ();
  truth_table_sweeper_if #(.N(N)) bus_b ();

  assign bus_a.dut_out = tbl_a[bus_a.stim];
  assign bus_b.dut_out = tbl_b[bus_b.stim];

  truth_table_sweeper #(.N(N), .HOLD(HOLD_A), .EXPECT(EXP_A)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  truth_table_sweeper #(.N(N), .HOLD(HOLD_B), .EXPECT(EXP_B)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: result of a full sweep is just a bitwise comparison of tables.
  function automatic exp_t model(input logic [15:0] tbl, input logic [15:0] expv, input int acc);
    exp_t e;
    e.errs = 0; e.ff = 0; e.fv = 0; e.acc = acc;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] !== expv[i]) begin
        if (e.fv == 0) begin
          e.ff = i;
          e.fv = 1;
        end
        e.errs++;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus_a.busy && q_a.size() > 0)
      chk("a_stim_seq", int'(bus_a.stim), (cyc - q_a[0].acc) / HOLD_A);
    if (bus_a.done && !done_a_q) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_latency", cyc - e.acc, 16 * HOLD_A);
        chk("a_err_count", int'(bus_a.err_count), e.errs);
        chk("a_first_fail", int'(bus_a.first_fail), e.ff);
        chk("a_fail_valid", int'(bus_a.fail_valid), e.fv);
        chk("a_pass", int'(bus_a.pass), (e.errs == 0) ? 1 : 0);
        chk("a_busy_at_done", int'(bus_a.busy), 0);
      end
    end
    done_a_q <= bus_a.done;
  end

  always @(negedge clk) begin
    if (bus_b.busy && q_b.size() > 0)
      chk("b_stim_seq", int'(bus_b.stim), (cyc - q_b[0].acc) / HOLD_B);
    if (bus_b.done && !done_b_q) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_latency", cyc - e.acc, 16 * HOLD_B);
        chk("b_err_count", int'(bus_b.err_count), e.errs);
        chk("b_first_fail", int'(bus_b.first_fail), e.ff);
        chk("b_fail_valid", int'(bus_b.fail_valid), e.fv);
        chk("b_pass", int'(bus_b.pass), (e.errs == 0) ? 1 : 0);
        chk("b_busy_at_done", int'(bus_b.busy), 0);
      end
    end
    done_b_q <= bus_b.done;
  end

  task automatic pulse_a(input logic [15:0] t, input bit accepted);
    @(negedge clk);
    tbl_a = t;
    bus_a.start = 1'b1;
    if (accepted) q_a.push_back(model(t, EXP_A, cyc + 1));
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic pulse_b(input logic [15:0] t);
    @(negedge clk);
    tbl_b = t;
    bus_b.start = 1'b1;
    q_b.push_back(model(t, EXP_B, cyc + 1));
    @(negedge clk);
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!bus_a.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.done) chk("a_done_timeout", 0, 1);
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (!bus_b.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_b.done) chk("b_done_timeout", 0, 1);
  endtask

  task automatic wait_stim_a(input int v);
    int n = 0;
    while (int'(bus_a.stim) != v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (int'(bus_a.stim) != v) chk("a_stim_wait_timeout", int'(bus_a.stim), v);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    tbl_a = '0;
    tbl_b = '0;
    repeat (3) @(negedge clk);
    chk("a_reset_state", int'({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                                bus_a.first_fail, bus_a.fail_valid}), 0);
    chk("b_reset_state", int'({bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
                                bus_b.first_fail, bus_b.fail_valid}), 0);
    rst = 1'b0;

    // 4-input AND against 16'h8000, then a single mismatch at vector 0.
    pulse_a(16'h8000, 1'b1);
    wait_done_a();
    pulse_a(16'h8001, 1'b1);
    wait_done_a();

    // Start during RUN is ignored.
    pulse_a(16'h8000, 1'b1);
    wait_stim_a(5);
    pulse_a(16'h8000, 1'b0);
    wait_done_a();

    // Restart from FINISH with two errors logged.
    pulse_a(16'h8006, 1'b1);
    wait_done_a();
    chk("a_finish_err2", int'(bus_a.err_count), 2);
    pulse_a(16'h8006, 1'b1);
    chk("a_restart_busy", int'(bus_a.busy), 1);
    chk("a_restart_done", int'(bus_a.done), 0);
    chk("a_restart_err", int'(bus_a.err_count), 0);
    chk("a_restart_stim", int'(bus_a.stim), 0);
    wait_done_a();

    // Abort at vector 7 after three errors, then a clean sweep.
    pulse_a(16'h8015, 1'b1);
    wait_stim_a(7);
    chk("a_err_before_abort", int'(bus_a.err_count), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(q_a.pop_front());
    chk("a_abort_state", int'({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                                bus_a.first_fail, bus_a.fail_valid}), 0);
    pulse_a(16'h8000, 1'b1);
    wait_done_a();

    for (int k = 0; k < 4; k++) begin
      if (k[0]) pulse_a(16'($urandom), 1'b1);
      else      pulse_a(EXP_A ^ (16'd1 << $urandom_range(15, 0)), 1'b1);
      wait_done_a();
    end

    // HOLD=1: DUT tied low against all-ones expectation, then exact match.
    pulse_b(16'h0000);
    wait_done_b();
    pulse_b(16'hFFFF);
    wait_done_b();
    for (int k = 0; k < 4; k++) begin
      pulse_b(16'($urandom));
      wait_done_b();
    end

    repeat (2) @(negedge clk);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N, default 4: number of DUT inputs (1..8).
REQ-002 SHALL have parameter HOLD, default 10: clock cycles each input vector is held (>=1).
REQ-003 SHALL have parameter EXPECT, default all-zero, width 2**N: expected DUT output, bit i for input vector i.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a sweep; sampled on clk.
REQ-007 SHALL have port dut_out, input, 1: DUT response to stim.
REQ-008 SHALL have port stim, output, N: current input vector to DUT, MSB = first DUT input.
REQ-009 SHALL have port busy, output, 1: sweep in progress.
REQ-010 SHALL have port done, output, 1: sweep complete; results valid.
REQ-011 SHALL have port pass, output, 1: no mismatches; meaningful only while done=1.
REQ-012 SHALL have port err_count, output, N+1: number of mismatching vectors.
REQ-013 SHALL have port first_fail, output, N: lowest vector index that mismatched.
REQ-014 SHALL have port fail_valid, output, 1: first_fail holds a captured index.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-016 IDLE: start=1 at an edge -> RUN on that edge, stim=0, hold counter=0, err_count=0, fail_valid=0, first_fail=0.
REQ-017 RUN: hold counter increments each cycle, 0..HOLD-1; stim stays constant for exactly HOLD cycles.
REQ-018 RUN, edge where hold counter=HOLD-1: compare dut_out against EXPECT[stim]; on mismatch, increment err_count.
REQ-019 On a mismatch with fail_valid=0: capture first_fail=stim and set fail_valid=1; later mismatches leave both unchanged.
REQ-020 Same edge: if stim != 2**N-1, increment stim and clear the hold counter; else -> FINISH with stim held at all-ones.
REQ-021 End detection SHALL use the stim all-ones compare, never counter overflow; stim SHALL NOT wrap to 0 within a sweep.
REQ-022 Latency: done rises exactly 2**N * HOLD cycles after the edge that accepted start.
REQ-023 busy=1 exactly while in RUN; done=1 exactly while in FINISH; never both.
REQ-024 pass SHALL equal (err_count==0) while in FINISH; pass=0 in IDLE and RUN.
REQ-025 start while in RUN SHALL be ignored; the sweep continues undisturbed.
REQ-026 FINISH: outputs held until start=1, which restarts the sweep exactly as from IDLE (REQ-016) on the same edge.
REQ-027 err_count SHALL saturate-free count to 2**N; width N+1 guarantees no overflow.
REQ-028 HOLD=1 SHALL be legal: one compare per cycle, latency 2**N.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_valid=0; rst overrides start.
REQ-030 rst asserted mid-RUN SHALL abort the sweep with no partial results retained; the next start begins at vector 0.

Structure
REQ-031 FSM state encodings and the HOLD counter width rule (clog2 of HOLD) SHALL live in a shared header included by the module and its bench.
REQ-032 The hold timer SHALL be a sub-module hold_timer (HOLD param; clear, enable in; last out); the rest stays in truth_table_sweeper.

Verification
REQ-033 N=4, HOLD=10, EXPECT=16'h8000, DUT=4-input AND, one start pulse -> stim counts 0..15, done at cycle 160, pass=1, err_count=0, fail_valid=0.
REQ-034 Same setup with EXPECT=16'h8001 -> done at 160, pass=0, err_count=1, first_fail=0, fail_valid=1.
REQ-035 N=4, HOLD=1, EXPECT=16'hFFFF, DUT tied 0 -> done at cycle 16, err_count=16, first_fail=0.
REQ-036 Start pulsed again at vector 5 during RUN -> ignored; done still at 160 after the first accepted start.
REQ-037 rst for one cycle at vector 7 with 3 errors logged -> all outputs 0 next cycle; a new start gives a full clean sweep of 160 cycles.
REQ-038 start asserted in FINISH with err_count=2 -> next cycle busy=1, done=0, err_count=0, stim=0.
